// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared definitions for the immediate-extension unit.
//   - imm_mode_e    : extension mode encodings carried on in_mode.
//   - IMM_BUF_DEPTH : depth of the output buffer in imm_ext_pipe.
//   - imm_entry_t   : {data, tag, err, fused} buffer record laid out for the
//                     default configuration (32-bit operand, 5-bit tag).
// Optional feature macro: IMM_FUSE_EN (LUI/ORI constant fusion in mode 4).
package imm_ext_pkg;

  typedef enum logic [2:0] {
    IMM_MODE_ZERO        = 3'd0,
    IMM_MODE_SIGN        = 3'd1,
    IMM_MODE_UPPER       = 3'd2,
    IMM_MODE_BRANCH      = 3'd3,
    IMM_MODE_LOWER_MERGE = 3'd4
  } imm_mode_e;

  localparam int IMM_BUF_DEPTH  = 2;
  localparam int IMM_DEF_DATA_W = 32;
  localparam int IMM_DEF_TAG_W  = 5;

  typedef struct packed {
    logic [IMM_DEF_DATA_W-1:0] data;
    logic [IMM_DEF_TAG_W-1:0]  tag;
    logic                      err;
    logic                      fused;
  } imm_entry_t;

endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: purely combinational immediate decode/extension, shared with
// the single-cycle datapath.
// Ports:
//   imm        in  IMM_W   raw immediate field
//   mode       in  3       extension mode (imm_mode_e encoding)
//   merge_hit  in  1       (IMM_FUSE_EN only) held UPPER matches this op's tag
//   merge_base in  DATA_W  (IMM_FUSE_EN only) held UPPER result
//   data       out DATA_W  extended operand (0 for reserved modes)
//   err        out 1       reserved mode
//   fused      out 1       result is a fused LUI/ORI constant
// Optional feature macro: IMM_FUSE_EN. Without it mode 4 is reserved.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        mode,
`ifdef IMM_FUSE_EN
  input  logic              merge_hit,
  input  logic [DATA_W-1:0] merge_base,
`endif
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              fused
);

  localparam int PAD_W = DATA_W - IMM_W;

  imm_mode_e         mode_s;
  logic [DATA_W-1:0] zext_s;
  logic [DATA_W-1:0] sext_s;

  assign mode_s = imm_mode_e'(mode);
  assign zext_s = {{PAD_W{1'b0}}, imm};
  assign sext_s = {{PAD_W{imm[IMM_W-1]}}, imm};

  // Select the extended operand; unknown modes yield zero data with err set.
  always_comb begin
    data  = {DATA_W{1'b0}};
    err   = 1'b0;
    fused = 1'b0;
    case (mode_s)
      IMM_MODE_ZERO:   data = zext_s;
      IMM_MODE_SIGN:   data = sext_s;
      IMM_MODE_UPPER:  data = {imm, {PAD_W{1'b0}}};
      // Top two bits of the sign-extended value fall off the end.
      IMM_MODE_BRANCH: data = {sext_s[DATA_W-3:0], 2'b00};
`ifdef IMM_FUSE_EN
      IMM_MODE_LOWER_MERGE: begin
        if (merge_hit) begin
          data  = merge_base | zext_s;
          fused = 1'b1;
        end else begin
          data  = zext_s;
          fused = 1'b0;
        end
      end
`endif
      default: begin
        data = {DATA_W{1'b0}};
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with a 2-entry output FIFO.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready depends only on state)
//   in_imm, in_mode      raw immediate and extension mode
//   in_tag               destination tag, carried through unchanged
//   out_valid/out_ready  result handshake for the FIFO head
//   out_data, out_tag    head operand and its tag
//   out_err              head had a reserved mode
//   out_fused            head is a fused LUI/ORI constant (0 without fusion)
// Optional feature macro: IMM_FUSE_EN enables UPPER/LOWER_MERGE fusion.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              out_fused
);

  // Same shape as imm_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
    logic              fused;
  } entry_t;

  localparam int ENTRY_W = DATA_W + TAG_W + 2;

  entry_t            fifo_r [0:IMM_BUF_DEPTH-1];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;
  logic [1:0]        count_next_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] ext_data_s;
  logic              ext_err_s;
  logic              ext_fused_s;

`ifdef IMM_FUSE_EN
  logic [DATA_W-1:0] held_upper_r;
  logic [TAG_W-1:0]  held_tag_r;
  logic              upper_live_r;
  logic              merge_hit_s;

  assign merge_hit_s = upper_live_r & (in_tag == held_tag_r);
`endif

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  imm_ext_comb #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_comb (
    .imm        (in_imm),
    .mode       (in_mode),
`ifdef IMM_FUSE_EN
    .merge_hit  (merge_hit_s),
    .merge_base (held_upper_r),
`endif
    .data       (ext_data_s),
    .err        (ext_err_s),
    .fused      (ext_fused_s)
  );

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Occupancy and handshake flags; both flags are registered copies of the
  // next count so neither depends combinationally on the current inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != 2'd2);
      out_valid_r <= (count_next_s != 2'd0);
    end
  end

  // FIFO storage and pointers; entries are cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      for (int i = 0; i < IMM_BUF_DEPTH; i++) begin
        fifo_r[i] <= entry_t'({ENTRY_W{1'b0}});
      end
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= '{data: ext_data_s, tag: in_tag,
                               err: ext_err_s, fused: ext_fused_s};
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

`ifdef IMM_FUSE_EN
  // Track the most recent accepted UPPER op; any other accepted op ends the pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_upper_r <= {DATA_W{1'b0}};
      held_tag_r   <= {TAG_W{1'b0}};
      upper_live_r <= 1'b0;
    end else if (push_s) begin
      if (in_mode == IMM_MODE_UPPER) begin
        held_upper_r <= ext_data_s;
        held_tag_r   <= in_tag;
        upper_live_r <= 1'b1;
      end else begin
        upper_live_r <= 1'b0;
      end
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = fifo_r[rd_ptr_r].data;
  assign out_tag   = fifo_r[rd_ptr_r].tag;
  assign out_err   = fifo_r[rd_ptr_r].err;
  assign out_fused = fifo_r[rd_ptr_r].fused;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: self-checking bench for imm_ext_pipe (DATA_W=32, IMM_W=16,
// TAG_W=5). A queue-based reference model tracks expected FIFO contents.
// Optional feature macro: IMM_FUSE_EN (fusion sequences compiled in when set).
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic        out_fused;

  imm_ext_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .out_fused (out_fused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
    logic        fused;
  } ent_t;

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  ent_t q[$];

  // Fusion state of the reference model.
  logic        m_live = 1'b0;
  logic [31:0] m_held = 32'd0;
  logic [4:0]  m_tag  = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: compute the operand from the mode rules with plain arithmetic.
  function automatic ent_t model_op(input logic [15:0] imm, input logic [2:0] mode,
                                    input logic [4:0] tag);
    ent_t e;
    int unsigned zx;
    int sx;
    zx = int'(imm);
    sx = imm[15] ? int'(imm) - 65536 : int'(imm);
    e.tag = tag; e.err = 1'b0; e.fused = 1'b0; e.data = 32'd0;
    case (mode)
      3'd0: e.data = zx;
      3'd1: e.data = sx;
      3'd2: e.data = zx * 65536;
      3'd3: e.data = sx * 4;
`ifdef IMM_FUSE_EN
      3'd4: begin
        if (m_live && tag == m_tag) begin
          e.data = m_held | zx;
          e.fused = 1'b1;
        end else begin
          e.data = zx;
        end
      end
`endif
      default: e.err = 1'b1;
    endcase
    if (mode == 3'd2) begin
      m_live = 1'b1; m_held = e.data; m_tag = tag;
    end else begin
      m_live = 1'b0;
    end
    return e;
  endfunction

  // Compare DUT against the model, advance the model by this cycle's
  // handshakes, then move to 1 time unit after the next rising edge.
  task automatic tick();
    logic push;
    logic pop;
    ent_t e;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      chk("head_data", out_data, q[0].data);
      chk("head_tag", {27'd0, out_tag}, {27'd0, q[0].tag});
      chk("head_err", {31'd0, out_err}, {31'd0, q[0].err});
      chk("head_fused", {31'd0, out_fused}, {31'd0, q[0].fused});
    end
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() != 0);
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (push) begin
      e = model_op(in_imm, in_mode, in_tag);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                       input logic [4:0] tag);
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{16'h8001, 3'd1, 5'd1, 32'hFFFF8001, 1'b0};
    vt[1] = '{16'h8001, 3'd0, 5'd2, 32'h00008001, 1'b0};
    vt[2] = '{16'h1234, 3'd2, 5'd3, 32'h12340000, 1'b0};
    vt[3] = '{16'hFFFF, 3'd3, 5'd4, 32'hFFFFFFFC, 1'b0};
    vt[4] = '{16'hABCD, 3'd6, 5'd5, 32'h00000000, 1'b1};
    vt[5] = '{16'h7FFF, 3'd1, 5'd6, 32'h00007FFF, 1'b0};
    vt[6] = '{16'h8000, 3'd3, 5'd7, 32'hFFFE0000, 1'b0};
`ifdef IMM_FUSE_EN
    vt[7] = '{16'h5678, 3'd4, 5'd8, 32'h00005678, 1'b0};
`else
    vt[7] = '{16'h5678, 3'd4, 5'd8, 32'h00000000, 1'b1};
`endif
    vt[8] = '{16'hFFFF, 3'd5, 5'd9, 32'h00000000, 1'b1};
    vt[9] = '{16'h0001, 3'd7, 5'd31, 32'h00000000, 1'b1};

    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: each result must be the head one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vt[i].imm, vt[i].mode, vt[i].tag);
      tick();
      drive(1'b0, 16'd0, 3'd0, 5'd0);
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_data", out_data, vt[i].exp_data);
      chk("tbl_err", {31'd0, out_err}, {31'd0, vt[i].exp_err});
      chk("tbl_tag", {27'd0, out_tag}, {27'd0, vt[i].tag});
      tick();
    end

    // Back-pressure: three ops offered with the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd0, 5'd1); tick();
    drive(1'b1, 16'h0022, 3'd1, 5'd2); tick();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h0033, 3'd2, 5'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_head_stable", out_data, 32'h00000011);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    for (int i = 0; i < 3; i++) tick();

    // Simultaneous push/pop at count 1 for 10 cycles.
    out_ready = 1'b0;
    drive(1'b1, 16'h0100, 3'd0, 5'd10); tick();
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom), 3'($urandom_range(0, 3)), 5'(i));
      chk("pp_valid_ready", {30'd0, out_valid, in_ready}, 32'd3);
      tick();
    end
    chk("pp_throughput", pops, 32'd10);
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    for (int i = 0; i < 2; i++) tick();

`ifdef IMM_FUSE_EN
    drive(1'b1, 16'h1234, 3'd2, 5'd7); tick();
    drive(1'b1, 16'h5678, 3'd4, 5'd7); tick();
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    chk("fuse_hit_data", out_data, 32'h12345678);
    chk("fuse_hit_fused", {31'd0, out_fused}, 32'd1);
    tick();
    drive(1'b1, 16'h1234, 3'd2, 5'd7); tick();
    drive(1'b1, 16'h5678, 3'd4, 5'd8); tick();
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    chk("fuse_miss_data", out_data, 32'h00005678);
    chk("fuse_miss_fused", {31'd0, out_fused}, 32'd0);
    chk("fuse_miss_err", {31'd0, out_err}, 32'd0);
    tick();
`endif

    // Randomized traffic with small tag range so fusion pairs occur.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)));
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end

    // Mid-stream reset with the buffer full.
    out_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 3'd1, 5'd21);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("arst_out_err", {31'd0, out_err}, 32'd0);
    chk("arst_out_fused", {31'd0, out_fused}, 32'd0);
    q.delete();
    m_live = 1'b0; m_held = 32'd0; m_tag = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    drive(1'b1, 16'h0042, 3'd0, 5'd2); tick();
    drive(1'b0, 16'd0, 3'd0, 5'd0);
    for (int i = 0; i < 2; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised successor to the fixed 16-to-32 upper-immediate shifter.
- Accepts an instruction immediate field plus an extension mode, and produces a DATA_W-bit operand.
- Sits between decode and the ALU-operand mux.
- Registered, one-cycle latency, valid/ready on both sides, 2-entry output buffer so decode can be back-pressured by a stalled execute stage.

Parameters:
- DATA_W, 32, output operand width; must be ≥ IMM_W+2.
- IMM_W, 16, immediate field width.
- TAG_W, 5, register tag width carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IMM_W  raw immediate field.
- in_mode  in  3  extension mode (encodings in package).
- in_tag  in  TAG_W  destination register tag, passed through.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  extended operand.
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry had a reserved mode.
- out_fused  out  1  head entry is a fused LUI/ORI constant (always 0 without IMM_FUSE_EN).

Behaviour:
- Modes:
  - 0 ZERO: zero-extend.
  - 1 SIGN: sign-extend from in_imm[IMM_W-1].
  - 2 UPPER: in_imm placed at bits [DATA_W-1 : DATA_W-IMM_W], low bits 0.
  - 3 BRANCH: sign-extend, then shift left 2; bits shifted out past DATA_W are dropped.
  - 4 LOWER_MERGE: fusion only, see optional feature.
  - 5–7 reserved: out_data = 0, out_err = 1.
- Transfers: accept when in_valid & in_ready; deliver when out_valid & out_ready.
- Buffer: 2-entry FIFO, with a count register 0..2.
  - in_ready = (count != 2), registered from count, with no combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: data accepted at edge N is visible on out_data after edge N when the buffer was empty, i.e. one cycle.
- Ordering: strictly FIFO.
- Push and pop in the same cycle at count 1: count stays 1, the head advances to the new entry.
  - At count 2, push is impossible (in_ready low); a pop makes in_ready high in the next cycle.
- out_data, out_tag, out_err and out_fused hold stable while out_valid & !out_ready.
- Reset, asynchronous, also mid-operation:
  - count = 0; in_ready = 1; out_valid = 0.
  - out_data, out_tag, out_err, out_fused = 0.
  - Read/write pointers = 0; fusion state cleared.
  - Any entries in flight are discarded.

Optional Feature:
- Macro: IMM_FUSE_EN.
- When defined:
  - Each accepted UPPER op stores its result and tag in a held register and sets upper_live.
  - An accepted LOWER_MERGE op whose in_tag equals the held tag while upper_live = 1 produces held_upper | zero-extend(in_imm), with out_fused = 1.
  - An accepted LOWER_MERGE op with a tag mismatch or upper_live = 0 produces zero-extend(in_imm), with out_fused = 0 and out_err = 0.
  - upper_live clears on any accepted non-UPPER op.
  - Back-to-back UPPER ops: the latest one overwrites the held register.
- When undefined: mode 4 is treated as reserved (err = 1, data = 0), and out_fused is tied 0.

Decomposition:
- Package imm_ext_pkg holds:
  - mode encodings: IMM_MODE_ZERO, IMM_MODE_SIGN, IMM_MODE_UPPER, IMM_MODE_BRANCH, IMM_MODE_LOWER_MERGE;
  - the buffer depth constant, IMM_BUF_DEPTH = 2;
  - an entry record type {data, tag, err, fused}.
- One sub-module, imm_ext_comb: the purely combinational mode decode/extension, so it can be shared with the single-cycle datapath.
- The top level holds the buffer, count and fusion state.

Test Plan:
- Reset asserted mid-stream with count = 2: all outputs 0 and in_ready = 1 immediately (asynchronously), with no stale entry after release.
- Extension values, DATA_W = 32, IMM_W = 16, out_ready = 1:
  - imm 0x8001 SIGN → 0xFFFF8001.
  - imm 0x8001 ZERO → 0x00008001.
  - imm 0x1234 UPPER → 0x12340000.
  - imm 0xFFFF BRANCH → 0xFFFFFFFC.
  - Each appears exactly one cycle after acceptance.
- Back-pressure: out_ready = 0 while pushing 3 ops.
  - The first two are accepted and in_ready drops after the second.
  - The third stalls with outputs stable.
  - out_ready = 1 drains them in order, with the tags matching.
- Simultaneous push/pop at count 1 over 10 consecutive cycles: count stays 1, throughput is one op per cycle, and order is preserved.
- Mode 6 with imm 0xABCD: out_err = 1 and out_data = 0.
- With IMM_FUSE_EN:
  - UPPER 0x1234 tag 7, then LOWER_MERGE 0x5678 tag 7 → 0x12345678 with out_fused = 1.
  - The same sequence with tag 8 on the merge → 0x00005678 with out_fused = 0.
